// File: rtl/alk_carry_seq_pkg.sv
// Shared definitions for the ALU carry sequencer.
//   ALUCI codes : carry source select encodings below the extra-source range
//   div_state_t : divide sequencer states
package alk_pkg;

   localparam int unsigned CI_ZERO = 0;
   localparam int unsigned CI_ALKC = 1;
   localparam int unsigned CI_ONE  = 2;
   localparam int unsigned CI_PSLC = 3;
   // Codes at or above this value select ext_ci[code - CI_EXT_BASE].
   localparam int unsigned CI_EXT_BASE = 4;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_LAST = 2'd2
   } div_state_t;

endpackage

// File: rtl/alk_carry_seq_if.sv
// Handshake/bus bundle for alk_carry_seq.
//   master : drives the microcycle controls and ALU feedback, reads results
//   slave  : the carry sequencer itself
interface alk_carry_seq_if #(parameter int CI_W = 2);
   logic                 step_h;
   logic [CI_W-1:0]      aluci_h;
   logic                 force_cout0_h;
   logic                 alpctl_divdbl_h;
   logic                 alkc_load_h;
   logic                 alu_cout_h;
   logic                 alu_sign_h;
   logic                 pslc_flag_h;
   logic [2**CI_W-1:0]   ext_ci_h;
   logic                 div_start_h;
   logic                 carry_out_l;
   logic                 alkc_flag_h;
   logic                 q_bit_h;
   logic                 div_busy_h;
   logic                 div_done_h;

   modport master (
      output step_h, aluci_h, force_cout0_h, alpctl_divdbl_h, alkc_load_h,
             alu_cout_h, alu_sign_h, pslc_flag_h, ext_ci_h, div_start_h,
      input  carry_out_l, alkc_flag_h, q_bit_h, div_busy_h, div_done_h
   );

   modport slave (
      input  step_h, aluci_h, force_cout0_h, alpctl_divdbl_h, alkc_load_h,
             alu_cout_h, alu_sign_h, pslc_flag_h, ext_ci_h, div_start_h,
      output carry_out_l, alkc_flag_h, q_bit_h, div_busy_h, div_done_h
   );
endinterface

// File: rtl/alk_carry_seq_cmux.sv
// Combinational ALU carry-in source mux.
//   aluci      : source select
//   alkc       : registered ALKC flag
//   pslc       : PSL<C>
//   ext_ci     : extra sources, selected by codes >= 4
//   force_zero : kills the aluci-selected term only
//   divdbl     : ORs ALKC in after the force
//   carry      : selected carry, active high
module alk_cmux
   import alk_pkg::*;
#(
   parameter int CI_W = 2
) (
   input  logic [CI_W-1:0]    aluci,
   input  logic               alkc,
   input  logic               pslc,
   input  logic [2**CI_W-1:0] ext_ci,
   input  logic               force_zero,
   input  logic               divdbl,
   output logic               carry
);

   logic [CI_W-1:0] ext_idx;
   logic            sel_carry;

   always_comb begin
      ext_idx   = aluci - CI_W'(CI_EXT_BASE);
      sel_carry = 1'b0;
      if (aluci == CI_W'(CI_ZERO))
         sel_carry = 1'b0;
      else if (aluci == CI_W'(CI_ALKC))
         sel_carry = alkc;
      else if (aluci == CI_W'(CI_ONE))
         sel_carry = 1'b1;
      else if (aluci == CI_W'(CI_PSLC))
         sel_carry = pslc;
      else
         sel_carry = ext_ci[ext_idx];
      // DIVDBL must still inject ALKC when the normal source is forced off.
      carry = (sel_carry & ~force_zero) | (divdbl & alkc);
   end

endmodule

// File: rtl/alk_carry_seq.sv
// ALU carry-in sequencer with ALKC flag and non-restoring divide control.
//   clk_h   : microcycle clock
//   reset_l : asynchronous active-low reset
//   bus     : controls, ALU feedback and results (see alk_carry_seq_if)
//
// state    | meaning
// DIV_IDLE | no divide; carry_invert is 0
// DIV_RUN  | divide step; next step adds or subtracts from ~alu_sign
// DIV_LAST | final step; pulses div_done_h and clears carry_invert
module alk_carry_seq
   import alk_pkg::*;
#(
   parameter int CI_W      = 2,
   parameter int DIV_STEPS = 32,
   parameter int CNT_W     = $clog2(DIV_STEPS + 1)
) (
   input  logic           clk_h,
   input  logic           reset_l,
   alk_carry_seq_if.slave bus
);

   div_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             alkc, alkc_nx;
   logic             carry_invert, carry_invert_nx;
   logic             div_done;
   logic             cmux;

   alk_cmux #(.CI_W(CI_W)) u_cmux (
      .aluci      (bus.aluci_h),
      .alkc       (alkc),
      .pslc       (bus.pslc_flag_h),
      .ext_ci     (bus.ext_ci_h),
      .force_zero (bus.force_cout0_h),
      .divdbl     (bus.alpctl_divdbl_h),
      .carry      (cmux)
   );

   always_ff @(posedge clk_h or negedge reset_l) begin
      if (!reset_l) begin
         state        <= DIV_IDLE;
         cnt          <= '0;
         alkc         <= 1'b0;
         carry_invert <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         alkc         <= alkc_nx;
         carry_invert <= carry_invert_nx;
      end
   end

   always_comb begin
      state_nx        = state;
      cnt_nx          = cnt;
      alkc_nx         = alkc;
      carry_invert_nx = carry_invert;
      div_done        = 1'b0;
      if (bus.step_h) begin
         if (bus.alkc_load_h)
            alkc_nx = bus.alu_cout_h;
         if (bus.div_start_h) begin
            // Start (or restart) always wins; the first step subtracts.
            cnt_nx          = CNT_W'(DIV_STEPS - 1);
            carry_invert_nx = 1'b1;
            state_nx        = (DIV_STEPS == 1) ? DIV_LAST : DIV_RUN;
         end else begin
            case (state)
               DIV_RUN: begin
                  carry_invert_nx = ~bus.alu_sign_h;
                  if (cnt != '0)
                     cnt_nx = cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1))
                     state_nx = DIV_LAST;
               end
               DIV_LAST: begin
                  div_done        = 1'b1;
                  carry_invert_nx = 1'b0;
                  state_nx        = DIV_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.carry_out_l = ~(cmux ^ carry_invert);
   assign bus.alkc_flag_h = alkc;
   assign bus.div_busy_h  = (state != DIV_IDLE);
   assign bus.q_bit_h     = (state != DIV_IDLE) & ~bus.alu_sign_h;
   assign bus.div_done_h  = div_done;

endmodule

// File: tb/tb_alk_carry_seq.sv
module tb_alk_carry_seq;

   logic       clk_h = 1'b0;
   logic       reset_l = 1'b0;
   logic       step = 1'b0, force0 = 1'b0, divdbl = 1'b0, load = 1'b0;
   logic       cout = 1'b0, sign = 1'b0, pslc = 1'b0, start = 1'b0;
   logic [2:0] aluci = '0;
   logic [7:0] ext = '0;

   int checks = 0;
   int errors = 0;

   // Reference state: steps remaining in the divide (0 = idle), invert flag, ALKC.
   int   m_left[2];
   logic m_inv[2];
   logic m_alkc[2];
   int   n_steps[2];

   logic o_cout[2], o_alkc[2], o_q[2], o_busy[2], o_done[2];

   always #5 clk_h = ~clk_h;

   alk_carry_seq_if #(.CI_W(2)) bus0 ();
   alk_carry_seq_if #(.CI_W(3)) bus1 ();

   assign bus0.step_h = step;           assign bus1.step_h = step;
   assign bus0.aluci_h = aluci[1:0];    assign bus1.aluci_h = aluci;
   assign bus0.force_cout0_h = force0;  assign bus1.force_cout0_h = force0;
   assign bus0.alpctl_divdbl_h = divdbl; assign bus1.alpctl_divdbl_h = divdbl;
   assign bus0.alkc_load_h = load;      assign bus1.alkc_load_h = load;
   assign bus0.alu_cout_h = cout;       assign bus1.alu_cout_h = cout;
   assign bus0.alu_sign_h = sign;       assign bus1.alu_sign_h = sign;
   assign bus0.pslc_flag_h = pslc;      assign bus1.pslc_flag_h = pslc;
   assign bus0.ext_ci_h = ext[3:0];     assign bus1.ext_ci_h = ext;
   assign bus0.div_start_h = start;     assign bus1.div_start_h = start;

   assign o_cout[0] = bus0.carry_out_l; assign o_cout[1] = bus1.carry_out_l;
   assign o_alkc[0] = bus0.alkc_flag_h; assign o_alkc[1] = bus1.alkc_flag_h;
   assign o_q[0]    = bus0.q_bit_h;     assign o_q[1]    = bus1.q_bit_h;
   assign o_busy[0] = bus0.div_busy_h;  assign o_busy[1] = bus1.div_busy_h;
   assign o_done[0] = bus0.div_done_h;  assign o_done[1] = bus1.div_done_h;

   alk_carry_seq #(.CI_W(2), .DIV_STEPS(4)) dut0 (
      .clk_h(clk_h), .reset_l(reset_l), .bus(bus0.slave));
   alk_carry_seq #(.CI_W(3), .DIV_STEPS(1)) dut1 (
      .clk_h(clk_h), .reset_l(reset_l), .bus(bus1.slave));

   function automatic logic exp_cout(int i);
      int   sel;
      logic c;
      sel = (i == 0) ? int'(aluci[1:0]) : int'(aluci);
      case (sel)
         0:       c = 1'b0;
         1:       c = m_alkc[i];
         2:       c = 1'b1;
         3:       c = pslc;
         default: c = ext[sel-4];
      endcase
      if (force0) c = 1'b0;
      c = c | (divdbl & m_alkc[i]);
      return ~(c ^ m_inv[i]);
   endfunction

   task automatic chk(input string tag, input int i, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s dut%0d observed %b expected %b", tag, i, obs, expv);
      end
   endtask

   task automatic compare_all(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, ".carry_out_l"}, i, o_cout[i], exp_cout(i));
         chk({tag, ".alkc"}, i, o_alkc[i], m_alkc[i]);
         chk({tag, ".busy"}, i, o_busy[i], m_left[i] > 0);
         chk({tag, ".q"}, i, o_q[i], (m_left[i] > 0) ? ~sign : 1'b0);
         chk({tag, ".done"}, i, o_done[i],
             reset_l && step && !start && m_left[i] == 1);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_left[i] = 0; m_inv[i] = 1'b0; m_alkc[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      if (!step) return;
      for (int i = 0; i < 2; i++) begin
         if (load) m_alkc[i] = cout;
         if (start) begin
            m_left[i] = n_steps[i];
            m_inv[i]  = 1'b1;
         end else if (m_left[i] > 0) begin
            m_inv[i]  = (m_left[i] > 1) ? ~sign : 1'b0;
            m_left[i] = m_left[i] - 1;
         end
      end
   endtask

   // Called at a negedge with inputs already set.
   task automatic cyc(input string tag);
      #1;
      compare_all(tag);
      @(posedge clk_h);
      model_edge();
      @(negedge clk_h);
   endtask

   task automatic clear_in();
      step = 0; force0 = 0; divdbl = 0; load = 0; cout = 0;
      sign = 0; pslc = 0; start = 0; aluci = '0; ext = '0;
   endtask

   task automatic mid_reset(input string tag);
      #2 reset_l = 1'b0;
      #1 model_reset();
      compare_all(tag);
      @(negedge clk_h);
      reset_l = 1'b1;
   endtask

   initial begin
      logic [3:0] signs;
      n_steps[0] = 4; n_steps[1] = 1;
      model_reset();
      clear_in();
      @(negedge clk_h);
      compare_all("reset");
      aluci = 3'd2;
      #1 compare_all("reset_mux");
      reset_l = 1'b1;
      clear_in();

      // ALKC load, then source mux with ALKC=1, PSL<C>=0
      step = 1; load = 1; cout = 1;
      cyc("alkc_load");
      clear_in();
      for (int a = 1; a <= 3; a++) begin
         aluci = 3'(a);
         cyc("mux");
      end
      chk("mux_pslc_direct", 0, o_cout[0], 1'b1);
      force0 = 1; aluci = 3'd2;
      cyc("force");
      chk("force_direct", 0, o_cout[0], 1'b1);
      divdbl = 1;
      #1 chk("force_divdbl_direct", 0, o_cout[0], 1'b0);
      cyc("force_divdbl");
      clear_in();

      // Plain divide: signs 1,0,0,1 after start
      signs = 4'b1001;
      step = 1; start = 1; aluci = 3'd1;
      cyc("div_start");
      start = 0;
      for (int k = 3; k >= 0; k--) begin
         sign = signs[k];
         if (k == 0) begin
            #1 chk("div_done_4th", 0, o_done[0], 1'b1);
         end
         cyc("div_step");
      end
      sign = 0;
      #1 chk("div_busy_fall", 0, o_busy[0], 1'b0);
      cyc("div_after");

      // Stall mid-run
      start = 1;
      cyc("stall_start");
      start = 0; sign = 1;
      cyc("stall_s1");
      step = 0;
      for (int k = 0; k < 3; k++) begin
         sign = 1'($urandom);
         cyc("stall_hold");
      end
      step = 1;
      for (int k = 0; k < 4; k++) begin
         sign = 1'($urandom);
         cyc("stall_resume");
      end

      // Restart at step 2
      start = 1;
      cyc("rst_start");
      start = 0; sign = 0;
      cyc("rst_s1");
      start = 1;
      cyc("restart");
      start = 0;
      for (int k = 0; k < 5; k++) begin
         sign = 1'($urandom);
         cyc("restart_run");
      end

      // Reset at step 3 with ALKC set
      start = 1; load = 1; cout = 1;
      cyc("abort_start");
      start = 0; load = 0;
      cyc("abort_s1");
      cyc("abort_s2");
      mid_reset("abort_reset");
      chk("abort_alkc_direct", 0, o_alkc[0], 1'b0);
      chk("abort_busy_direct", 0, o_busy[0], 1'b0);

      // Wider select on the CI_W=3 instance; single-step divide on it too
      clear_in();
      aluci = 3'd5; ext = 8'b0000_0010;
      #1 chk("ext_sel_direct", 1, o_cout[1], 1'b0);
      cyc("ext_sel");
      step = 1; start = 1;
      cyc("one_step_start");
      start = 0;
      #1 chk("one_step_done", 1, o_done[1], 1'b1);
      cyc("one_step_done_cyc");

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         step   = ($urandom_range(0, 3) != 0);
         aluci  = 3'($urandom);
         force0 = ($urandom_range(0, 3) == 0);
         divdbl = ($urandom_range(0, 3) == 0);
         load   = ($urandom_range(0, 2) == 0);
         cout   = 1'($urandom);
         sign   = 1'($urandom);
         pslc   = 1'($urandom);
         ext    = 8'($urandom);
         start  = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 99) == 0)
            mid_reset("rand_reset");
         else
            cyc("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alk_carry_seq.md
ALK_CARRY_SEQ -- requirements
Module: alk_carry_seq

Interface
REQ-001 Parameter CI_W, default 2: width of the ALUCI select field; legal range 2..4.
REQ-002 Parameter DIV_STEPS, default 32: number of divide iterations; legal range 1..64.
REQ-003 Parameter CNT_W, default $clog2(DIV_STEPS+1): width of the step counter.
REQ-004 The interface SHALL be as follows; one clock; reset is asynchronous and active-low:
- clk_h  in  1  microcycle clock.
- reset_l  in  1  asynchronous active-low reset.
- step_h  in  1  microcycle enable; all state holds while low.
- aluci_h  in  CI_W  carry source select.
- force_cout0_h  in  1  forces the selected carry to 0.
- alpctl_divdbl_h  in  1  DIVDBL step; carry = ALKC.
- alkc_load_h  in  1  load ALKC from alu_cout_h.
- alu_cout_h  in  1  ALU carry out of the current cycle.
- alu_sign_h  in  1  ALU result sign of the current cycle.
- pslc_flag_h  in  1  PSL<C>.
- ext_ci_h  in  2**CI_W  extra carry sources.
- div_start_h  in  1  start a divide sequence.
- carry_out_l  out  1  ALU carry input, active low.
- alkc_flag_h  out  1  registered ALKC flag.
- q_bit_h  out  1  quotient bit of the current step.
- div_busy_h  out  1  divide sequence active.
- div_done_h  out  1  one-cycle completion pulse.

Function
REQ-005 Carry mux (cmux), combinational:
- aluci 0 -> 0.
- aluci 1 -> ALKC.
- aluci 2 -> 1.
- aluci 3 -> PSL<C>.
- aluci k>=4 -> ext_ci_h[k-4].
REQ-006 force_cout0_h SHALL zero the aluci term only; the alpctl_divdbl_h term (ALKC) SHALL be ORed in after forcing.
REQ-007 carry_out_l SHALL equal ~(cmux ^ carry_invert), where carry_invert is a register.
REQ-008 carry_out_l SHALL be combinational from its inputs and registered state, with zero cycles of latency.
REQ-009 ALKC update, on a rising edge with step_h=1 and alkc_load_h=1: ALKC <= alu_cout_h.
REQ-010 The divide FSM SHALL have three states: IDLE, RUN, LAST.
REQ-011 IDLE:
- div_start_h with step_h loads cnt=DIV_STEPS-1 and sets carry_invert=1 (first step subtracts).
- The next state is RUN, or LAST when DIV_STEPS=1.
REQ-012 RUN: each step_h cycle sets carry_invert <= ~alu_sign_h and decrements cnt; when cnt reaches 1 (i.e., 1 before decrement), the next state is LAST.
REQ-013 LAST: the step_h cycle SHALL pulse div_done_h=1 for that one cycle, set carry_invert <= 0, and return to IDLE.
REQ-014 q_bit_h SHALL equal ~alu_sign_h in RUN and LAST, and 0 in IDLE.
REQ-015 div_busy_h SHALL be 1 in RUN and LAST.
REQ-016 div_start_h in RUN or LAST SHALL restart the sequence (same as IDLE entry); div_done_h is not pulsed on restart.
REQ-017 With step_h=0, the FSM, cnt, ALKC and carry_invert SHALL hold; div_done_h SHALL be 0.
REQ-018 In IDLE, carry_invert SHALL be 0, so carry_out_l = ~cmux.
REQ-019 The counter SHALL never wrap; cnt is unused outside RUN.

Reset
REQ-020 reset_l=0 SHALL asynchronously set: FSM=IDLE, cnt=0, ALKC=0, carry_invert=0.
REQ-021 Outputs during reset:
- div_busy_h=0, div_done_h=0, q_bit_h=0.
- carry_out_l = ~cmux (1 when aluci=0).
REQ-022 Reset asserted mid-divide SHALL abort the sequence without a done pulse.

Structure
REQ-023 The shared package alk_pkg SHALL hold:
- the ALUCI codes (CI_ZERO, CI_ALKC, CI_ONE, CI_PSLC);
- the FSM state enum (DIV_IDLE, DIV_RUN, DIV_LAST).
REQ-024 One sub-module SHALL be used: alk_cmux (combinational carry mux, parametrised by CI_W); the FSM and registers stay in the top level.

Verification
REQ-025 Mux check: aluci=1..3 with ALKC=1, PSL<C>=0, force_cout0_h=0 -> carry_out_l = 0, 0, 1 respectively.
REQ-026 Force check: force_cout0_h=1, aluci=2 -> carry_out_l=1; adding alpctl_divdbl_h=1 with ALKC=1 -> carry_out_l=0.
REQ-027 Divide run: DIV_STEPS=4, div_start_h, then alu_sign_h = 1, 0, 0, 1 with continuous step_h:
- q_bit_h = 0, 1, 1, 0;
- div_done_h pulses on the 4th step;
- div_busy_h falls the next cycle.
REQ-028 Stall: drop step_h for 3 cycles mid-RUN -> cnt, carry_invert and q sequence unchanged; done is delayed by 3 cycles.
REQ-029 Restart and reset: div_start_h at step 2 -> the sequence restarts with the full count and no done pulse; reset_l=0 at step 3 -> IDLE immediately, ALKC=0.
REQ-030 Parameter sweep: CI_W=3 with aluci=5 and ext_ci_h[1]=1 -> carry_out_l=0; DIV_STEPS=1 -> div_done_h on the first step.
